// File: rtl/mdu_multicycle.sv
// rtl/mdu_multicycle.sv - multi-cycle multiply/divide unit owning the HI/LO registers
// Results are computed at the start edge and held in pending registers until the latency expires.
module mdu_multicycle #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       MDUOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Flush,
   output logic             Start,
   output logic             Busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] MFOut
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] pend_hi, pend_lo;
   logic             pend_we;
   logic             accept, finish, mt_hi, mt_lo;

   logic                 is_mult, is_div, b_zero;
   logic [2*WIDTH-1:0]   prod_s, prod_u, res;
   logic                 res_we;
   logic [WIDTH-1:0]     a_mag, b_mag, q_mag, r_mag, quo_s, rem_s, quo_u, rem_u, dvs_u;

   assign is_mult = (MDUOp == 4'd1) || (MDUOp == 4'd2);
   assign is_div  = (MDUOp == 4'd3) || (MDUOp == 4'd4);
   assign Start   = is_mult || is_div;
   assign Busy    = (state == RUN);
   assign b_zero  = (B == '0);

   assign prod_s = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
   assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

   // Signed divide via magnitudes; most-negative / -1 naturally wraps back to most-negative.
   // A zero divisor is replaced by 1 only to keep the datapath defined; the result is never written.
   assign a_mag = A[WIDTH-1] ? -A : A;
   assign b_mag = b_zero ? WIDTH'(1) : (B[WIDTH-1] ? -B : B);
   assign q_mag = a_mag / b_mag;
   assign r_mag = a_mag % b_mag;
   assign quo_s = (A[WIDTH-1] ^ B[WIDTH-1]) ? -q_mag : q_mag;
   assign rem_s = A[WIDTH-1] ? -r_mag : r_mag;
   assign dvs_u = b_zero ? WIDTH'(1) : B;
   assign quo_u = A / dvs_u;
   assign rem_u = A % dvs_u;

   always_comb begin
      res    = '0;
      res_we = 1'b1;
      case (MDUOp)
         4'd1:    res = prod_s;
         4'd2:    res = prod_u;
         4'd3:    begin res = {rem_s, quo_s}; res_we = !b_zero; end
         4'd4:    begin res = {rem_u, quo_u}; res_we = !b_zero; end
         default: res = '0;
      endcase
   end

   always_comb begin
      MFOut = '0;
      if (MDUOp == 4'd5)      MFOut = HI;
      else if (MDUOp == 4'd6) MFOut = LO;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      finish    = 1'b0;
      mt_hi     = 1'b0;
      mt_lo     = 1'b0;
      if (Flush) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  accept    = 1'b1;
                  state_nxt = RUN;
                  cnt_nxt   = is_mult ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
               end
               mt_hi = (MDUOp == 4'd7);
               mt_lo = (MDUOp == 4'd8);
            end
            RUN: begin
               if (cnt == '0) begin
                  finish    = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_we <= 1'b0;
         HI      <= '0;
         LO      <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            pend_hi <= res[2*WIDTH-1:WIDTH];
            pend_lo <= res[WIDTH-1:0];
            pend_we <= res_we;
         end else if (Flush || finish) begin
            pend_we <= 1'b0;
         end
         if (finish && pend_we) begin
            HI <= pend_hi;
            LO <= pend_lo;
         end
         if (mt_hi) HI <= A;
         if (mt_lo) LO <= A;
      end
   end

endmodule

// File: tb/tb_mdu_multicycle.sv
// tb/tb_mdu_multicycle.sv - self-checking bench for mdu_multicycle against an arithmetic model
module tb_mdu_multicycle;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  MDUOp;
   logic [31:0] A, B;
   logic        Flush;
   logic        Start, Busy;
   logic [31:0] HI, LO, MFOut;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] m_hi, m_lo;

   mdu_multicycle #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B), .Flush(Flush),
      .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MFOut(MFOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural effect of one accepted operation on the HI/LO model.
   task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
         4'd2: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
         4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = 32'(q); m_hi = 32'(r); end
         4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
         4'd7: m_hi = a;
         4'd8: m_lo = a;
         default: ;
      endcase
   endtask

   // Issue an MDU start, optionally poking another op during Busy, and check latency and HI/LO.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] poke_op, input logic [31:0] poke_a);
      int n;
      MDUOp = op; A = a; B = b;
      #1;
      check({tag, "_start"}, 64'(Start), 64'd1);
      tick();
      model_op(op, a, b);
      MDUOp = 4'd0;
      n = 0;
      while (Busy && n < 100) begin
         n++;
         MDUOp = (n == 2) ? poke_op : 4'd0;
         A = (n == 2) ? poke_a : a;
         tick();
      end
      MDUOp = 4'd0;
      check({tag, "_busy"}, 64'(n), (op == 4'd1 || op == 4'd2) ? 64'd5 : 64'd10);
      check({tag, "_hilo"}, {HI, LO}, {m_hi, m_lo});
   endtask

   task automatic mt_op(input string tag, input logic [3:0] op, input logic [31:0] a);
      MDUOp = op; A = a;
      tick();
      model_op(op, a, 32'd0);
      MDUOp = 4'd0;
      check({tag, "_busy"}, 64'(Busy), 64'd0);
      check({tag, "_hilo"}, {HI, LO}, {m_hi, m_lo});
   endtask

   initial begin
      logic [3:0] ops [6];
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      int n;
      ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
      reset = 1'b1; MDUOp = 4'd0; A = '0; B = '0; Flush = 1'b0;
      m_hi = '0; m_lo = '0;
      repeat (2) tick();
      check("reset_state", {31'b0, Busy, HI, LO}, 64'd0);
      MDUOp = 4'd3; #1;
      check("start_comb_in_reset", 64'(Start), 64'd1);
      MDUOp = 4'd9; #1;
      check("start_op9", 64'(Start), 64'd0);
      MDUOp = 4'd0;
      reset = 1'b0;
      tick();

      run_op("mult_neg", 4'd1, 32'hFFFFFFFD, 32'd5, 4'd0, 32'd0);
      check("mult_neg_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFF1);
      run_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 4'd0, 32'd0);
      check("multu_const", {HI, LO}, 64'h00000001_FFFFFFFE);
      MDUOp = 4'd6; #1;
      check("mflo", 64'(MFOut), 64'(m_lo));
      MDUOp = 4'd5; #1;
      check("mfhi", 64'(MFOut), 64'(m_hi));
      MDUOp = 4'd0; #1;
      check("mf_none", 64'(MFOut), 64'd0);
      tick();

      run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 4'd0, 32'd0);
      check("div_neg_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
      run_op("divu_zero", 4'd4, 32'd7, 32'd0, 4'd0, 32'd0);
      run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 4'd0, 32'd0);
      check("div_ovf_const", {HI, LO}, 64'h00000000_80000000);
      run_op("div_zero", 4'd3, 32'h80000000, 32'd0, 4'd0, 32'd0);

      mt_op("mthi", 4'd7, 32'h12345678);
      run_op("mult_mtlo_busy", 4'd1, 32'd3, 32'd4, 4'd8, 32'h0000DEAD);
      run_op("mult_start_busy", 4'd2, 32'd9, 32'd9, 4'd1, 32'd1);
      mt_op("mtlo", 4'd8, 32'hCAFEF00D);

      // Flush on the 4th Busy cycle of a div.
      MDUOp = 4'd3; A = 32'd100; B = 32'd7;
      tick();
      MDUOp = 4'd0;
      repeat (3) tick();
      check("flush_busy_before", 64'(Busy), 64'd1);
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      check("flush_busy_after", 64'(Busy), 64'd0);
      repeat (12) tick();
      check("flush_hilo_kept", {HI, LO}, {m_hi, m_lo});

      Flush = 1'b1; MDUOp = 4'd1; A = 32'd2; B = 32'd3;
      tick();
      check("flush_start_busy", 64'(Busy), 64'd0);
      MDUOp = 4'd7; A = 32'h55555555;
      tick();
      Flush = 1'b0; MDUOp = 4'd0;
      check("flush_mthi_hilo", {HI, LO}, {m_hi, m_lo});

      // Asynchronous reset between edges during a mult.
      MDUOp = 4'd1; A = 32'd11; B = 32'd13;
      tick();
      MDUOp = 4'd0;
      tick();
      reset = 1'b1;
      #1;
      check("async_reset", {31'b0, Busy, HI, LO}, 64'd0);
      m_hi = '0; m_lo = '0;
      #1;
      reset = 1'b0;
      tick();
      run_op("mult_6x7", 4'd1, 32'd6, 32'd7, 4'd0, 32'd0);
      check("mult_6x7_lo", 64'(LO), 64'd42);

      for (int i = 0; i < 24; i++) begin
         rop = ops[$urandom_range(0, 5)];
         ra = $urandom();
         rb = $urandom();
         n = $urandom_range(0, 7);
         if (n == 0) rb = 32'd0;
         if (n == 1) rb = 32'hFFFFFFFF;
         if (n == 2) rb = $urandom_range(1, 9);
         if (n == 3) ra = 32'h80000000;
         if (rop == 4'd7 || rop == 4'd8) mt_op("rand_mt", rop, ra);
         else run_op("rand_op", rop, ra, rb, 4'(($urandom_range(0, 1) == 0) ? 4'd0 : 4'd8), $urandom());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
- Multi-cycle multiply/divide unit for the 5-stage MIPS pipeline. It sits in the E stage beside the ALU and owns the HI/LO registers.
- Executes mult/multu/div/divu with parametrised latency and handles mthi/mtlo writes.
- Exposes Start/Busy so hazard logic can stall later MDU instructions in D stage.
- Generalises the decoder's fixed MDUControl encoding into a parametrised-width, parametrised-latency sequential unit with abort support.

Parameters:
- WIDTH, 32, operand width; the HI/LO product is 2*WIDTH.
- MULT_CYCLES, 5, Busy cycles for mult/multu; must be >= 1.
- DIV_CYCLES, 10, Busy cycles for div/divu; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- MDUOp  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 are treated as none.
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- Flush  input  1  aborts the in-flight operation (exception/flush); HI/LO keep their values.
- Start  output  1  combinational: high when MDUOp is 1..4.
- Busy  output  WIDTH-independent 1  registered; high while an operation is in flight.
- HI  output  WIDTH  architectural HI register.
- LO  output  WIDTH  architectural LO register.
- MFOut  output  WIDTH  combinational: HI when MDUOp=5, LO when MDUOp=6, else 0.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - HI=0, LO=0, Busy=0; internal counter, pending results and op register cleared.
  - Start and MFOut follow their inputs combinationally.
- State machine has two states, IDLE and RUN.
- IDLE:
  - MDUOp 1..4 with Flush=0: capture the result at this edge into pending registers, load counter = MULT_CYCLES-1 or DIV_CYCLES-1, go to RUN, Busy=1 next cycle.
  - MDUOp 7: HI<=A at the edge. MDUOp 8: LO<=A at the edge. Busy stays 0.
  - MDUOp 5/6 have no state effect.
- RUN:
  - Each edge decrements the counter.
  - At the edge where the counter is 0: HI/LO<=pending (unless suppressed, see divide by zero), go to IDLE, Busy=0.
  - Busy is therefore high for exactly N cycles (N = configured latency). New HI/LO are visible on the same edge that Busy falls.
- MDUOp 1..4 and 7..8 arriving while Busy=1 are ignored; hazard logic must stall them using Start|Busy.
- Flush=1 in any state: go to IDLE, Busy=0, pending results discarded, HI/LO unchanged.
- Flush=1 in the same cycle as a start or mthi/mtlo: Flush wins; nothing is started or written.
- Arithmetic:
  - mult: signed WIDTH x WIDTH gives a 2*WIDTH result; HI=upper, LO=lower.
  - multu: the same, unsigned.
  - div: signed; LO=quotient truncated toward zero; HI=remainder, whose sign follows the dividend.
  - divu: unsigned quotient and remainder.
  - Signed overflow case (most-negative / -1): LO=most-negative, HI=0.
- Divide by zero (B=0, div or divu): the unit still goes Busy for DIV_CYCLES, but HI/LO are NOT written at completion.
- Back-to-back: a start is accepted in the first cycle after Busy falls. Zero bubbles are imposed beyond the latency.

Test Plan:
- Signed multiply: reset, then mult A=32'hFFFFFFFD (-3), B=5. Busy must be high exactly 5 cycles; HI=32'hFFFFFFFF and LO=32'hFFFFFFF1 on the edge Busy falls.
- Unsigned multiply: multu A=32'hFFFFFFFF, B=2 -> HI=32'h00000001, LO=32'hFFFFFFFE after 5 Busy cycles. MFOut=LO value when MDUOp=6.
- Signed divide: div A=32'hFFFFFFF9 (-7), B=2 -> after 10 Busy cycles LO=32'hFFFFFFFD and HI=32'hFFFFFFFF. Then divu A=7, B=0 -> Busy 10 cycles, HI/LO unchanged.
- Ops during Busy: mthi A=32'h12345678 in IDLE -> HI=32'h12345678 next edge. During a following mult, mtlo A=32'hDEAD is ignored; LO holds the mult result at completion.
- Flush mid-operation: start div 100/7, assert Flush on the 4th Busy cycle -> Busy=0 next edge, HI/LO retain their prior values. Flush and a mult start in the same cycle -> Busy stays 0.
- Asynchronous reset mid-operation: assert reset between edges during a mult -> HI=LO=0 and Busy=0 immediately, without waiting for a clock edge. After release, a new mult 6*7 gives LO=42.
